// File: rtl/wavetable_sample_reader_if.sv
// wavetable_sample_reader_if: Avalon-MM read port toward the sample RAM plus the valid/ready sample stream.
interface wavetable_sample_reader_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_chipselect;
   logic              avm_read;
   logic              avm_write;
   logic [1:0]        avm_byteenable;
   logic              avm_clken;
   logic [DATA_W-1:0] avm_readdata;
   logic [DATA_W-1:0] sample_data;
   logic              sample_valid;
   logic              sample_ready;
   modport master (
      output avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_clken,
      input  avm_readdata,
      output sample_data, sample_valid,
      input  sample_ready
   );
   modport slave (
      input  avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_clken,
      output avm_readdata,
      input  sample_data, sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/wavetable_sample_reader.sv
// wavetable_sample_reader: per-tick phase accumulator, Avalon-MM table read, one signed sample on a valid/ready stream.
// Define WAVETABLE_LINEAR_INTERP_EN to read idx and idx+1 and interpolate linearly on the phase fraction.
module wavetable_sample_reader #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 16,
   parameter int TABLE_AW     = 10,
   parameter int PHASE_W      = 32,
   parameter int FRAC_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               sample_tick,
   input  logic [PHASE_W-1:0] tuning_word,
   input  logic [ADDR_W-1:0]  table_base,
   output logic               overrun,
   input  logic               overrun_clr,
   wavetable_sample_reader_if.master bus
);
   localparam int WCW = READ_LATENCY > 2 ? $clog2(READ_LATENCY - 1) : 1;
   typedef enum logic [2:0] {IDLE, ISSUE, ISSUE1, WAIT, CAPTURE, MUL, OUT} state_t;
   state_t              state_q, state_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;
   logic [TABLE_AW-1:0] idx_q, idx_d, addr_idx;
   logic [WCW-1:0]      wcnt_q, wcnt_d;
   logic [DATA_W-1:0]   sample_data_q, sample_data_d;
   logic                overrun_q, overrun_d;
   logic                accept, drop, issuing;
   logic                unused_base;
   assign accept      = state_q == IDLE && enable && sample_tick;
   assign drop        = state_q != IDLE && enable && sample_tick;
   assign issuing     = state_q == ISSUE || state_q == ISSUE1;
   assign unused_base = ^table_base[TABLE_AW-1:0];
   assign addr_idx    = state_q == ISSUE1 ? idx_q + 1'b1 : idx_q;
   assign bus.avm_address    = issuing ? {table_base[ADDR_W-1:TABLE_AW], addr_idx} : '0;
   assign bus.avm_chipselect = issuing;
   assign bus.avm_read       = issuing;
   assign bus.avm_write      = 1'b0;
   assign bus.avm_byteenable = 2'b11;
   assign bus.avm_clken      = 1'b1;
   assign bus.sample_data    = sample_data_q;
   assign bus.sample_valid   = state_q == OUT;
   assign overrun            = overrun_q;
`ifdef WAVETABLE_LINEAR_INTERP_EN
   logic [FRAC_W-1:0]                frac_q, frac_d;
   logic [DATA_W-1:0]                rd_prev_q, rd_prev_d;
   logic signed [DATA_W-1:0]         s0_q, s0_d;
   logic signed [DATA_W+FRAC_W+1:0]  prod_q, prod_d;
   logic signed [DATA_W:0]           diff;
   // s1 is on readdata in CAPTURE; s0 arrived the cycle before and sits in rd_prev_q
   assign diff = $signed({bus.avm_readdata[DATA_W-1], bus.avm_readdata}) - $signed({rd_prev_q[DATA_W-1], rd_prev_q});
   always_comb begin
      frac_d    = accept ? phase_q[PHASE_W-TABLE_AW-1 -: FRAC_W] : frac_q;
      rd_prev_d = bus.avm_readdata;
      s0_d      = state_q == CAPTURE ? $signed(rd_prev_q) : s0_q;
      prod_d    = state_q == CAPTURE ? diff * $signed({1'b0, frac_q}) : prod_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         frac_q    <= '0;
         rd_prev_q <= '0;
         s0_q      <= '0;
         prod_q    <= '0;
      end else begin
         frac_q    <= frac_d;
         rd_prev_q <= rd_prev_d;
         s0_q      <= s0_d;
         prod_q    <= prod_d;
      end
`endif
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      idx_d         = idx_q;
      wcnt_d        = '0;
      sample_data_d = sample_data_q;
      overrun_d     = drop | (overrun_q & ~overrun_clr);
      case (state_q)
         IDLE: if (accept) begin
            state_d = ISSUE;
            idx_d   = phase_q[PHASE_W-1 -: TABLE_AW];
            phase_d = phase_q + tuning_word;
         end
`ifdef WAVETABLE_LINEAR_INTERP_EN
         ISSUE:   state_d = ISSUE1;
         ISSUE1:  state_d = READ_LATENCY > 1 ? WAIT : CAPTURE;
         CAPTURE: state_d = MUL;
         MUL: begin
            state_d       = OUT;
            sample_data_d = DATA_W'(s0_q + (prod_q >>> FRAC_W));
         end
`else
         ISSUE:   state_d = READ_LATENCY > 1 ? WAIT : CAPTURE;
         CAPTURE: begin
            state_d       = OUT;
            sample_data_d = bus.avm_readdata;
         end
`endif
         WAIT: begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = wcnt_q == WCW'(READ_LATENCY - 2) ? CAPTURE : WAIT;
         end
         OUT:     state_d = bus.sample_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q       <= IDLE;
         phase_q       <= '0;
         idx_q         <= '0;
         wcnt_q        <= '0;
         sample_data_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         idx_q         <= idx_d;
         wcnt_q        <= wcnt_d;
         sample_data_q <= sample_data_d;
         overrun_q     <= overrun_d;
      end
endmodule
